// File: rtl/note_event_capture_pkg.sv
// Shared widths and the event word layout for the note capture front end.
//   OCTAVE_BITS / NOTE_BITS / LENGTH_BITS / CLOCK_BITS : field widths
//   event_t     : packed event word {octave, note, length, clock}
//   pack_event  : builds an event word from its fields
package note_event_capture_pkg;

   localparam int OCTAVE_BITS = 4;
   // NOTE_BITS must hold NOTE_KEYS itself, which encodes "rest".
   localparam int NOTE_BITS   = 3;
   localparam int LENGTH_BITS = 3;
   localparam int CLOCK_BITS  = 16;

   typedef struct packed {
      logic [OCTAVE_BITS-1:0] octave;
      logic [NOTE_BITS-1:0]   note;
      logic [LENGTH_BITS-1:0] length;
      logic [CLOCK_BITS-1:0]  clock;
   } event_t;

   localparam int EVENT_BITS = $bits(event_t);

   function automatic event_t pack_event(
      input logic [OCTAVE_BITS-1:0] octave,
      input logic [NOTE_BITS-1:0]   note,
      input logic [LENGTH_BITS-1:0] length,
      input logic [CLOCK_BITS-1:0]  clock
   );
      event_t ev;
      ev.octave = octave;
      ev.note   = note;
      ev.length = length;
      ev.clock  = clock;
      return ev;
   endfunction

endpackage

// File: rtl/note_event_capture_fifo.sv
// Synchronous WIDTH x DEPTH FIFO for note events.
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write request and data
//   pop, rdata    : read request and head word (valid while !empty)
//   full, empty   : status
//   count         : occupancy, 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle.
module note_event_capture_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   // Extra pointer MSB separates full from empty when the slot indices match.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/note_event_capture.sv
// Single-voice key capture: decodes note/length keys and octave buttons into
// the current (octave, note, length) and queues every note change as a
// timestamped event drained through ev_valid/ev_ready.
//   clk, rst             : clock, synchronous active-high reset
//   en                   : capture enable; when low octave follows octave_in
//   octave_in            : octave loaded while disabled (clamped)
//   oct_up, oct_down     : debounced octave buttons, rising-edge sensitive
//   note_key, length_key : one-hot key inputs
//   system_clock         : timestamp source
//   octave, note, length : current state
//   ev_*                 : head-of-queue event and handshake
//   ev_count             : queue occupancy
//   overflow, clr_ovf    : sticky dropped-event flag and its clear
module note_event_capture
   import note_event_capture_pkg::*;
#(
   parameter int NOTE_KEYS     = 7,
   parameter int LENGTH_KEYS   = 7,
   parameter int OCT_MIN       = 0,
   parameter int OCT_MAX       = 7,
   parameter int OCT_RESET     = 4,
   parameter int LEN_RESET     = 2,
   parameter int DEPTH         = 8,
   parameter int RETRIG_ON_OCT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [OCTAVE_BITS-1:0]   octave_in,
   input  logic                     oct_up,
   input  logic                     oct_down,
   input  logic [NOTE_KEYS-1:0]     note_key,
   input  logic [LENGTH_KEYS-1:0]   length_key,
   input  logic [CLOCK_BITS-1:0]    system_clock,
   output logic [OCTAVE_BITS-1:0]   octave,
   output logic [NOTE_BITS-1:0]     note,
   output logic [LENGTH_BITS-1:0]   length,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic [OCTAVE_BITS-1:0]   ev_octave,
   output logic [NOTE_BITS-1:0]     ev_note,
   output logic [LENGTH_BITS-1:0]   ev_length,
   output logic [CLOCK_BITS-1:0]    ev_clock,
   output logic [$clog2(DEPTH):0]   ev_count,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam logic [NOTE_BITS-1:0] NOTE_REST = NOTE_BITS'(NOTE_KEYS);

   logic                   up_q, down_q;
   logic                   up_edge, down_edge;
   logic [OCTAVE_BITS-1:0] oct_next, oct_clamped;
   logic [NOTE_BITS-1:0]   note_next;
   logic [LENGTH_BITS-1:0] len_next;
   logic                   push_req;
   logic                   fifo_full, fifo_empty, fifo_pop, drop;
   event_t                 push_ev, head_ev;

   assign up_edge   = oct_up && !up_q;
   assign down_edge = oct_down && !down_q;

   always_comb begin
      note_next = note;
      if (note_key == '0) begin
         note_next = NOTE_REST;
      end else if ($countones(note_key) == 1) begin
         for (int i = 0; i < NOTE_KEYS; i++)
            if (note_key[i]) note_next = NOTE_BITS'(i);
      end
   end

   always_comb begin
      len_next = length;
      if ($countones(length_key) == 1) begin
         for (int i = 0; i < LENGTH_KEYS; i++)
            if (length_key[i]) len_next = LENGTH_BITS'(i);
      end
   end

   always_comb begin
      oct_next = octave;
      if (up_edge && !down_edge && int'(octave) < OCT_MAX)
         oct_next = octave + OCTAVE_BITS'(1);
      else if (down_edge && !up_edge && int'(octave) > OCT_MIN)
         oct_next = octave - OCTAVE_BITS'(1);
   end

   always_comb begin
      oct_clamped = octave_in;
      if (int'(octave_in) > OCT_MAX)
         oct_clamped = OCTAVE_BITS'(OCT_MAX);
      else if (int'(octave_in) < OCT_MIN)
         oct_clamped = OCTAVE_BITS'(OCT_MIN);
   end

   // Retrigger only when the octave really moves (not at a saturated bound).
   assign push_req = en && !rst &&
                     ((note_next != note) ||
                      (RETRIG_ON_OCT != 0 && oct_next != octave && note_next != NOTE_REST));

   assign push_ev  = pack_event(oct_next, note_next, len_next, system_clock);
   assign fifo_pop = ev_valid && ev_ready;
   assign drop     = push_req && fifo_full && !fifo_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         octave   <= OCTAVE_BITS'(OCT_RESET);
         note     <= NOTE_REST;
         length   <= LENGTH_BITS'(LEN_RESET);
         up_q     <= 1'b0;
         down_q   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         // History follows the buttons even while disabled so re-enable is edge-free.
         up_q   <= oct_up;
         down_q <= oct_down;
         if (en) begin
            octave <= oct_next;
            note   <= note_next;
            length <= len_next;
         end else begin
            octave <= oct_clamped;
            note   <= NOTE_REST;
         end
         if (drop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

   note_event_capture_fifo #(
      .WIDTH (EVENT_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .wdata (push_ev),
      .pop   (fifo_pop),
      .rdata (head_ev),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (ev_count)
   );

   assign ev_valid  = !fifo_empty;
   assign ev_octave = head_ev.octave;
   assign ev_note   = head_ev.note;
   assign ev_length = head_ev.length;
   assign ev_clock  = head_ev.clock;

endmodule

// File: tb/tb_note_event_capture.sv
module tb_note_event_capture;
   import note_event_capture_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   en = 1'b1;
   logic [OCTAVE_BITS-1:0] octave_in = '0;
   logic                   oct_up = 1'b0, oct_down = 1'b0;
   logic [6:0]             note_key = '0;
   logic [6:0]             length_key = '0;
   logic [CLOCK_BITS-1:0]  sys_clk = 16'h0100;
   logic                   ev_ready = 1'b0;
   logic                   clr_ovf = 1'b0;

   logic [OCTAVE_BITS-1:0] octave, ev_octave;
   logic [NOTE_BITS-1:0]   note, ev_note;
   logic [LENGTH_BITS-1:0] length, ev_length;
   logic [CLOCK_BITS-1:0]  ev_clock;
   logic                   ev_valid, overflow;
   logic [3:0]             ev_count;

   logic [OCTAVE_BITS-1:0] nr_octave, nr_ev_octave;
   logic [NOTE_BITS-1:0]   nr_note, nr_ev_note;
   logic [LENGTH_BITS-1:0] nr_length, nr_ev_length;
   logic [CLOCK_BITS-1:0]  nr_ev_clock;
   logic                   nr_ev_valid, nr_overflow;
   logic [3:0]             nr_ev_count;
   logic                   nr_ready = 1'b1;

   int     n_cmp = 0;
   int     n_err = 0;
   event_t exp_q[$];
   event_t mon_e;

   always #5 clk = ~clk;

   note_event_capture dut (
      .clk(clk), .rst(rst), .en(en), .octave_in(octave_in),
      .oct_up(oct_up), .oct_down(oct_down), .note_key(note_key),
      .length_key(length_key), .system_clock(sys_clk),
      .octave(octave), .note(note), .length(length),
      .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_octave(ev_octave), .ev_note(ev_note), .ev_length(ev_length),
      .ev_clock(ev_clock), .ev_count(ev_count),
      .overflow(overflow), .clr_ovf(clr_ovf)
   );

   note_event_capture #(.RETRIG_ON_OCT(0)) dut_nr (
      .clk(clk), .rst(rst), .en(en), .octave_in(octave_in),
      .oct_up(oct_up), .oct_down(oct_down), .note_key(note_key),
      .length_key(length_key), .system_clock(sys_clk),
      .octave(nr_octave), .note(nr_note), .length(nr_length),
      .ev_valid(nr_ev_valid), .ev_ready(nr_ready),
      .ev_octave(nr_ev_octave), .ev_note(nr_ev_note), .ev_length(nr_ev_length),
      .ev_clock(nr_ev_clock), .ev_count(nr_ev_count),
      .overflow(nr_overflow), .clr_ovf(clr_ovf)
   );

   // Monitor: a handshake seen at the falling edge is popped at the next rising edge.
   always @(negedge clk) begin
      if (!rst && ev_valid && ev_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got oct=%0d note=%0d len=%0d clk=%0h, expected none",
                     ev_octave, ev_note, ev_length, ev_clock);
         end else begin
            mon_e = exp_q.pop_front();
            if ({ev_octave, ev_note, ev_length, ev_clock} !== mon_e) begin
               n_err++;
               $display("FAIL event: got oct=%0d note=%0d len=%0d clk=%0h, expected oct=%0d note=%0d len=%0d clk=%0h",
                        ev_octave, ev_note, ev_length, ev_clock,
                        mon_e.octave, mon_e.note, mon_e.length, mon_e.clock);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      sys_clk = sys_clk + 16'd3;
   endtask

   // Expected event uses the timestamp the DUT will sample at the coming edge.
   task automatic expect_ev(input int o, input int n, input int l);
      exp_q.push_back(pack_event(OCTAVE_BITS'(o), NOTE_BITS'(n), LENGTH_BITS'(l), sys_clk));
   endtask

   task automatic pulse_up();
      oct_up = 1'b1; step(); oct_up = 1'b0; step();
   endtask

   task automatic pulse_down();
      oct_down = 1'b1; step(); oct_down = 1'b0; step();
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         step();
         k++;
      end
      step();
      chk(name, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_oct;

      // Reset and idle enable
      rst = 1'b1; step(); step();
      rst = 1'b0; step();
      chk("reset_octave", octave, 4);
      chk("reset_note", note, 7);
      chk("reset_length", length, 2);
      chk("reset_ev_valid", ev_valid, 0);
      chk("reset_overflow", overflow, 0);
      chk("reset_ev_count", ev_count, 0);

      // Note press, release, chord
      ev_ready = 1'b1;
      expect_ev(4, 2, 2); note_key = 7'b0000100; step();
      chk("press_note", note, 2);
      chk("press_ev_valid", ev_valid, 1);
      expect_ev(4, 7, 2); note_key = 7'b0000000; step();
      chk("release_note", note, 7);
      expect_ev(4, 2, 2); note_key = 7'b0000100; step();
      note_key = 7'b0000110; length_key = 7'b0100000; step();
      chk("chord_note", note, 2);
      chk("length_decode", length, 5);
      length_key = 7'b0110000; step();
      chk("length_multi_keep", length, 5);
      length_key = 7'b0100000;
      expect_ev(4, 7, 5); note_key = 7'b0000000; step();
      wait_drain("drain_notes");

      // Octave saturation at rest: no retrigger events expected
      exp_oct = 4;
      for (int i = 0; i < 7; i++) begin
         pulse_up();
         exp_oct = (exp_oct < 7) ? exp_oct + 1 : 7;
         chk("oct_up_sat", octave, exp_oct);
      end
      for (int i = 0; i < 8; i++) begin
         pulse_down();
         exp_oct = (exp_oct > 0) ? exp_oct - 1 : 0;
         chk("oct_down_sat", octave, exp_oct);
      end
      pulse_up();
      chk("oct_up_from_0", octave, 1);
      oct_up = 1'b1; oct_down = 1'b1; step();
      oct_up = 1'b0; oct_down = 1'b0; step();
      chk("oct_both_edges", octave, 1);
      oct_up = 1'b1; step(); step(); step();
      oct_up = 1'b0; step();
      chk("oct_held_once", octave, 2);

      // Retrigger on octave change with a held note
      expect_ev(2, 3, 5); note_key = 7'b0001000; step();
      wait_drain("drain_note3");
      expect_ev(3, 3, 5); oct_up = 1'b1; step();
      chk("retrig_ev_valid", ev_valid, 1);
      chk("noretrig_ev_valid", nr_ev_valid, 0);
      chk("retrig_octave", octave, 3);
      oct_up = 1'b0; step();
      expect_ev(3, 7, 5); note_key = 7'b0000000; step();
      wait_drain("drain_retrig");

      // Overflow: 9 changes into 8 entries, last one dropped
      ev_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         expect_ev(3, i, 5);
         note_key = 7'(1 << i);
         step();
      end
      expect_ev(3, 7, 5); note_key = 7'b0000000; step();
      note_key = 7'b0000001; step();
      chk("full_count", ev_count, 8);
      chk("overflow_set", overflow, 1);
      expect_ev(3, 1, 5); note_key = 7'b0000010; ev_ready = 1'b1; step();
      chk("push_pop_full_count", ev_count, 8);
      chk("overflow_sticky", overflow, 1);
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      chk("overflow_clear", overflow, 0);
      wait_drain("drain_overflow");

      // Mid-stream reset discards queue and same-cycle push
      ev_ready = 1'b0;
      expect_ev(3, 2, 5); note_key = 7'b0000100; step();
      expect_ev(3, 3, 5); note_key = 7'b0001000; step();
      expect_ev(3, 4, 5); note_key = 7'b0010000; step();
      chk("pre_reset_count", ev_count, 3);
      rst = 1'b1; note_key = 7'b0100000;
      exp_q.delete();
      step();
      chk("rst_count", ev_count, 0);
      chk("rst_ev_valid", ev_valid, 0);
      chk("rst_note", note, 7);
      chk("rst_octave", octave, 4);
      note_key = 7'b0000000; step();
      rst = 1'b0; ev_ready = 1'b1; step();

      // Disable: octave follows clamped octave_in, no events
      en = 1'b0; octave_in = 4'd9; note_key = 7'b0000100; oct_up = 1'b1; step();
      chk("dis_clamp", octave, 7);
      chk("dis_note", note, 7);
      chk("dis_ev_valid", ev_valid, 0);
      oct_up = 1'b0; oct_down = 1'b1; step();
      chk("dis_ignore_btn", octave, 7);
      oct_down = 1'b0; octave_in = 4'd3; oct_up = 1'b1; step();
      chk("dis_load", octave, 3);
      chk("dis_count", ev_count, 0);
      note_key = 7'b0000000; en = 1'b1; step();
      chk("reenable_no_edge", octave, 3);
      oct_up = 1'b0; step();

      wait_drain("final_drain");
      chk("final_ev_valid", ev_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
